// File: rtl/lif_layer_scheduler.sv
// lif_layer_scheduler: time-multiplexes one shared LIF datapath across NEURONS
// virtual neurons to form a fully connected spiking layer. Each timestep:
// accept a spike vector, prime the weight memory, evaluate every neuron once,
// then hold the layer's spike vector until the consumer takes it.
module lif_layer_scheduler #(
    parameter int SYNAPSES       = 32,
    parameter int NEURONS        = 8,
    parameter int MEMBRANE_BITS  = $clog2(SYNAPSES) + 2,
    parameter int THRESHOLD_BITS = MEMBRANE_BITS - 1,
    parameter int IDX_BITS       = $clog2(NEURONS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [SYNAPSES-1:0]             in_spikes,
    input  logic [2:0]                      shift,
    input  logic [THRESHOLD_BITS-1:0]       threshold,
    input  logic                            clear_state,
    output logic [IDX_BITS-1:0]             weight_addr,
    input  logic [SYNAPSES-1:0]             weight_data,
    output logic [SYNAPSES-1:0]             dp_inputs,
    output logic [SYNAPSES-1:0]             dp_weights,
    output logic signed [MEMBRANE_BITS-1:0] dp_last_membrane,
    input  logic signed [MEMBRANE_BITS-1:0] dp_new_membrane,
    input  logic                            dp_is_spike,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NEURONS-1:0]              out_spikes,
    output logic [15:0]                     timestep,
    output logic                            busy
);

    typedef enum logic [1:0] {IDLE, PRIME, EVAL, EMIT} state_t;

    state_t                          state_q, state_d;
    logic [IDX_BITS-1:0]             idx_q, idx_d;
    logic [SYNAPSES-1:0]             spikes_q;
    logic signed [MEMBRANE_BITS-1:0] mem_q [NEURONS];
    logic [NEURONS-1:0]              out_spikes_q;
    logic [15:0]                     timestep_q;
    logic                            last_idx;
    logic                            accept;
    logic                            do_clear;

    // shift/threshold feed the datapath directly; the scheduler never looks at them
    logic unused_dp_cfg;
    assign unused_dp_cfg = ^{shift, threshold};

    assign last_idx = (idx_q == IDX_BITS'(NEURONS - 1));
    assign accept   = (state_q == IDLE) && in_valid;
    // clear is honoured only while idle so a running timestep is never corrupted
    assign do_clear = (state_q == IDLE) && clear_state;

    assign dp_inputs        = spikes_q;
    assign dp_weights       = weight_data;
    assign dp_last_membrane = mem_q[idx_q];
    assign out_spikes       = out_spikes_q;
    assign timestep         = timestep_q;
    assign busy             = (state_q != IDLE);

    // Next-state, index sequencing and handshake outputs
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        weight_addr = '0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = PRIME;
                    idx_d   = '0;
                end
            end
            PRIME: begin
                // row 0 was addressed here; it arrives in the first EVAL cycle
                state_d = EVAL;
                idx_d   = '0;
            end
            EVAL: begin
                // address one row ahead to cover the memory's one-cycle latency
                weight_addr = last_idx ? '0 : idx_q + 1'b1;
                idx_d       = idx_q + 1'b1;
                if (last_idx) begin
                    state_d = EMIT;
                    idx_d   = '0;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and neuron index registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Membranes, spike latches and timestep counter
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < NEURONS; n++) mem_q[n] <= '0;
            spikes_q     <= '0;
            out_spikes_q <= '0;
            timestep_q   <= '0;
        end else begin
            if (do_clear) begin
                for (int n = 0; n < NEURONS; n++) mem_q[n] <= '0;
                timestep_q <= '0;
            end
            if (accept) spikes_q <= in_spikes;
            if (state_q == EVAL) begin
                mem_q[idx_q]        <= dp_new_membrane;
                out_spikes_q[idx_q] <= dp_is_spike;
            end
            if (state_q == EMIT && out_ready) timestep_q <= timestep_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_lif_layer_scheduler.sv
// Bench for lif_layer_scheduler (SYNAPSES=8, NEURONS=4): stub datapath,
// synchronous weight memory, directed timesteps with hand-computed spike
// vectors pushed to a scoreboard and popped by an output monitor.
module tb_lif_layer_scheduler;
    localparam int SYN = 8;
    localparam int NEU = 4;
    localparam int MB  = 5;
    localparam int TB  = 4;
    localparam int IB  = 2;

    logic                 clk, reset, in_valid, in_ready, clear_state;
    logic [SYN-1:0]       in_spikes, weight_data, dp_inputs, dp_weights;
    logic [2:0]           shift;
    logic [TB-1:0]        threshold;
    logic [IB-1:0]        weight_addr;
    logic signed [MB-1:0] dp_last_membrane, dp_new_membrane;
    logic                 dp_is_spike, out_valid, out_ready, busy;
    logic [NEU-1:0]       out_spikes;
    logic [15:0]          timestep;

    lif_layer_scheduler #(.SYNAPSES(SYN), .NEURONS(NEU)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_spikes(in_spikes), .shift(shift), .threshold(threshold),
        .clear_state(clear_state), .weight_addr(weight_addr), .weight_data(weight_data),
        .dp_inputs(dp_inputs), .dp_weights(dp_weights), .dp_last_membrane(dp_last_membrane),
        .dp_new_membrane(dp_new_membrane), .dp_is_spike(dp_is_spike),
        .out_valid(out_valid), .out_ready(out_ready), .out_spikes(out_spikes),
        .timestep(timestep), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // stub datapath: saturating increment, spike = weight bit 0
    always_comb begin
        dp_new_membrane = (dp_last_membrane == 5'sd15) ? 5'sd15 : dp_last_membrane + 5'sd1;
        dp_is_spike     = dp_weights[0];
    end

    // synchronous weight memory
    logic [SYN-1:0] rows [NEU];
    always @(posedge clk) weight_data <= rows[weight_addr];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [NEU-1:0] spk;
        logic [15:0]    ts;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    // output monitor: one scoreboard entry per completed handshake
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected_output: got %0h expected none", out_spikes);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_out_spikes", 32'(out_spikes), 32'(mon_e.spk));
                chk("sb_timestep", 32'(timestep), 32'(mon_e.ts));
            end
        end
    end

    int mdl_mem [NEU];
    int mdl_ts = 0;
    int last_acc = 0;

    // one full timestep; entered and left at posedge+1 with the DUT idle
    task automatic run_ts(input logic [SYN-1:0] spk, input bit clr, input bit clr_mid,
                          input int stall, input bit b2b, input logic [NEU-1:0] exp_spk);
        exp_t e;
        in_valid    = 1'b1;
        in_spikes   = spk;
        clear_state = clr;
        out_ready   = (stall == 0);
        @(negedge clk);
        chk("accept_in_ready", 32'(in_ready), 1);
        if (b2b) chk("accept_gap", 32'(cyc - last_acc), 7);
        last_acc = cyc;
        if (clr) begin
            for (int n = 0; n < NEU; n++) mdl_mem[n] = 0;
            mdl_ts = 0;
        end
        e.spk = exp_spk;
        e.ts  = 16'(mdl_ts);
        sbq.push_back(e);
        @(posedge clk); #1;
        in_valid    = 1'b0;
        clear_state = 1'b0;
        in_spikes   = ~spk;
        @(negedge clk);
        chk("prime_addr", 32'(weight_addr), 0);
        chk("prime_busy", 32'(busy), 1);
        chk("prime_in_ready", 32'(in_ready), 0);
        for (int i = 0; i < NEU; i++) begin
            @(posedge clk); #1;
            clear_state = clr_mid && (i == 1);
            @(negedge clk);
            chk("eval_addr", 32'(weight_addr), 32'((i + 1) % NEU));
            chk("eval_last_mem", 32'(dp_last_membrane), 32'(mdl_mem[i]));
            chk("eval_inputs", 32'(dp_inputs), 32'(spk));
            chk("eval_weights", 32'(dp_weights), 32'(rows[i]));
            mdl_mem[i] = (mdl_mem[i] >= 15) ? 15 : mdl_mem[i] + 1;
        end
        @(posedge clk); #1;
        clear_state = 1'b0;
        @(negedge clk);
        chk("emit_valid", 32'(out_valid), 1);
        chk("emit_latency", 32'(cyc - last_acc), 6);
        if (stall > 0) begin
            for (int k = 1; k < stall; k++) begin
                @(posedge clk); #1;
                @(negedge clk);
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_spikes", 32'(out_spikes), 32'(exp_spk));
                chk("stall_in_ready", 32'(in_ready), 0);
                chk("stall_timestep", 32'(timestep), 32'(mdl_ts));
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        mdl_ts++;
        chk("post_in_ready", 32'(in_ready), 1);
        chk("post_out_valid", 32'(out_valid), 0);
        chk("post_timestep", 32'(timestep), 32'(mdl_ts));
    endtask

    task automatic set_rows(input logic [SYN-1:0] r0, r1, r2, r3);
        rows[0] = r0; rows[1] = r1; rows[2] = r2; rows[3] = r3;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_spikes = '0; clear_state = 1'b0;
        out_ready = 1'b1; shift = 3'd1; threshold = '0;
        for (int n = 0; n < NEU; n++) mdl_mem[n] = 0;
        set_rows(8'h01, 8'h00, 8'h01, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_addr", 32'(weight_addr), 0);
        chk("rst_timestep", 32'(timestep), 0);
        chk("rst_out_spikes", 32'(out_spikes), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // basic, then two back-to-back (persistence to mem=3)
        run_ts(8'hFF, 0, 0, 0, 0, 4'b0101);
        run_ts(8'hA5, 0, 0, 0, 1, 4'b0101);
        run_ts(8'h5A, 0, 0, 0, 1, 4'b0101);

        // new rows; clear pulsed mid-EVAL must be ignored; 10-cycle backpressure
        set_rows(8'h81, 8'hFE, 8'h01, 8'hFF);
        run_ts(8'h0F, 0, 1, 10, 0, 4'b1101);
        run_ts(8'hF0, 0, 0, 0, 0, 4'b1101);

        // clear while idle
        clear_state = 1'b1;
        @(posedge clk); #1;
        clear_state = 1'b0;
        for (int n = 0; n < NEU; n++) mdl_mem[n] = 0;
        mdl_ts = 0;
        chk("idle_clear_timestep", 32'(timestep), 0);
        set_rows(8'h01, 8'h00, 8'h01, 8'h00);
        run_ts(8'h11, 0, 0, 0, 0, 4'b0101);

        // clear coincident with acceptance, then confirm mem=1 afterwards
        run_ts(8'h22, 1, 0, 0, 0, 4'b0101);
        run_ts(8'h44, 0, 0, 0, 0, 4'b0101);

        // reset in EVAL at i=2
        in_valid = 1'b1; in_spikes = 8'h3C;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_addr_i2", 32'(weight_addr), 3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 1);
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_out_spikes", 32'(out_spikes), 0);
        chk("abort_timestep", 32'(timestep), 0);
        for (int n = 0; n < NEU; n++) mdl_mem[n] = 0;
        mdl_ts = 0;
        run_ts(8'h80, 0, 0, 0, 0, 4'b0101);

        chk("sb_drained", 32'(sbq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lif_layer_scheduler.md
Name: lif_layer_scheduler

Overview:
- Time-multiplexes one shared lif_logic datapath across NEURONS virtual neurons to form a fully connected spiking layer.
- Accepts one input spike vector per timestep over a valid/ready handshake.
- Fetches each neuron's weight row from an external synchronous weight memory and drives the shared datapath once per neuron.
- Holds all membrane potentials internally and emits the layer's output spike vector over a second valid/ready handshake.

Parameters:
- SYNAPSES, 32, inputs per neuron; width of the spike and weight vectors.
- NEURONS, 8, virtual neurons sequenced per timestep; must be >= 2.
- MEMBRANE_BITS, $clog2(SYNAPSES)+2, signed membrane width; must match the datapath.
- THRESHOLD_BITS, MEMBRANE_BITS-1, threshold width.
- IDX_BITS, $clog2(NEURONS), neuron index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- in_valid  in  1  input spike vector valid.
- in_ready  out  1  scheduler can accept a vector.
- in_spikes  in  SYNAPSES  input spikes for this timestep.
- shift  in  3  decay shift; passed through to the datapath.
- threshold  in  THRESHOLD_BITS  spike threshold; passed through to the datapath.
- clear_state  in  1  zero all membranes and the timestep counter.
- weight_addr  out  IDX_BITS  weight row address; memory returns the row one cycle later.
- weight_data  in  SYNAPSES  weight row for the address issued in the previous cycle.
- dp_inputs  out  SYNAPSES  to the datapath inputs.
- dp_weights  out  SYNAPSES  to the datapath weights; equals weight_data.
- dp_last_membrane  out  MEMBRANE_BITS  to the datapath last_membrane.
- dp_new_membrane  in  MEMBRANE_BITS  from the datapath.
- dp_is_spike  in  1  from the datapath.
- out_valid  out  1  out_spikes valid.
- out_ready  in  1  consumer accepts out_spikes.
- out_spikes  out  NEURONS  bit i = spike of neuron i this timestep.
- timestep  out  16  count of completed timesteps; wraps at 2^16.
- busy  out  1  high in any state except IDLE.

Behaviour:
- State: membrane array mem[0..NEURONS-1] (signed, MEMBRANE_BITS), spike latch, index idx, FSM {IDLE, PRIME, EVAL, EMIT}.
- reset (takes priority in every state, aborts any timestep):
  - FSM to IDLE; all mem, idx, out_spikes and timestep to 0.
  - Outputs: in_ready=1, out_valid=0, busy=0, weight_addr=0.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_spikes, idx=0, weight_addr=0, go to PRIME.
  - clear_state in IDLE zeroes mem and timestep. If clear_state and acceptance coincide, the clear applies first and the accepted timestep sees zero membranes.
  - clear_state in any other state is ignored.
- PRIME:
  - One cycle covering memory read latency; weight_addr=0.
  - Go to EVAL with idx=0.
- EVAL (exactly NEURONS cycles):
  - In the cycle with index i: weight_addr=i+1 (drive 0 when i=NEURONS-1), dp_weights=weight_data (row i), dp_inputs=latched spikes, dp_last_membrane=mem[i].
  - At the clock edge: mem[i]<=dp_new_membrane and out_spikes[i]<=dp_is_spike.
  - After i=NEURONS-1: go to EMIT.
- EMIT:
  - out_valid=1; out_spikes held stable until the handshake completes.
  - On out_ready: timestep++, go to IDLE.
  - out_ready low stalls indefinitely with no state change.
- Latency: out_valid first high NEURONS+2 cycles after the accepting edge.
- Throughput: at best one timestep per NEURONS+3 cycles; input acceptance is not overlapped with processing.
- shift and threshold are sampled combinationally by the datapath. They must be held constant while busy; if they change, the result is undefined but the FSM stays well-formed.
- dp_inputs is driven from the latched copy; changes on in_spikes while busy have no effect.
- Membranes persist across timesteps; only reset or clear_state zeroes them.

Test Plan (SYNAPSES=8, NEURONS=4):
- Bench datapath stub: dp_new_membrane = dp_last_membrane + 1 (saturating); dp_is_spike = dp_weights[0].
- Basic timestep:
  - Stimulus: after reset, weight rows {8'h01, 8'h00, 8'h01, 8'h00}, in_spikes=8'hFF accepted at cycle 0, out_ready=1.
  - Required: out_valid first high at cycle 6, out_spikes=4'b0101, timestep=1, all mem=1.
- Persistence: three back-to-back timesteps → all mem=3, timestep=3. Two consecutive acceptances are exactly 7 cycles apart.
- Backpressure: hold out_ready=0 for 10 cycles in EMIT → out_valid and out_spikes stable, in_ready=0, timestep unchanged. Release → IDLE next cycle.
- Weight addressing: check the weight_addr sequence 0 (PRIME), 1, 2, 3, 0 (EVAL). Also check dp_last_membrane equals mem[i] in each EVAL cycle.
- clear_state:
  - Pulsed during EVAL → ignored.
  - Pulsed in IDLE after 2 timesteps → mem=0, timestep=0.
  - Coincident with acceptance → the resulting mem=1.
- Reset mid-EVAL (i=2) → next cycle IDLE, in_ready=1, out_valid=0, out_spikes=0, all mem=0.
